axi_reg_slice: RTL and testbench

AXI_REG_SLICE -- requirements
Module: axi_reg_slice

---
 rtl/axi_reg_slice.sv | 257 +++++++++++++++++++++++++
 tb/tb_axi_reg_slice.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_reg_slice.sv
`default_nettype none
// ============================================================================
//  Module   : axi_reg_slice_chan / axi_reg_slice
//  Purpose  : AXI4 register slice. Each of the five channels (AW, W, AR
//             forward s->m; B, R forward m->s) goes through its own 2-entry
//             skid buffer. Every ready, valid and payload output comes
//             straight from a flop, so no input reaches an output without
//             passing through a register.
//  Ports    : uncoreclk  - the only clock, rising edge
//             uncorerst  - asynchronous active-high reset
//             s_axi_*    - AXI4 slave side (from the upstream master)
//             m_axi_*    - AXI4 master side (toward the address mapper)
//  Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// axi_reg_slice_chan: one 2-entry skid buffer for a single valid/ready channel.
//   clk/rst                      - clock, async active-high reset
//   in_valid/in_ready/in_data    - upstream (producer) side
//   out_valid/out_ready/out_data - downstream (consumer) side
// ----------------------------------------------------------------------------
module axi_reg_slice_chan #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic [1:0]       count_q, count_d;
  logic             valid_q, valid_d;
  logic             ready_q, ready_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             push, pop;

  always_comb begin
    push    = in_valid & ready_q;
    pop     = valid_q & out_ready;
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case ({push, pop})
      2'b10: begin
        count_d = count_q + 2'd1;
        if (count_q == 2'd0) head_d = in_data;
        else                 tail_d = in_data;
      end
      2'b01: begin
        // With one entry left the tail copy is stale but valid drops, so
        // shifting unconditionally is harmless and keeps the mux small.
        count_d = count_q - 2'd1;
        head_d  = tail_q;
      end
      2'b11: begin
        // Push needs count<2 and pop needs count>=1, so count is exactly 1:
        // the incoming beat replaces the departing head directly.
        head_d = in_data;
      end
      default: ;
    endcase
    valid_d = (count_d != 2'd0);
    ready_d = (count_d != 2'd2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 2'd0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      count_q <= count_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  // Payload storage has no reset; it is only observed while valid is high.
  always_ff @(posedge clk) begin
    head_q <= head_d;
    tail_q <= tail_d;
  end

  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign out_data  = head_q;

endmodule

// ----------------------------------------------------------------------------
// axi_reg_slice: five independent channel slices. USER_WIDTH sizes the
// *user sideband fields on AW, AR, B and R.
// ----------------------------------------------------------------------------
module axi_reg_slice #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 8,
  parameter int USER_WIDTH = 1
) (
  input  logic                    uncoreclk,
  input  logic                    uncorerst,
  // AW slave
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic [2:0]              s_axi_awprot,
  input  logic [3:0]              s_axi_awcache,
  input  logic                    s_axi_awlock,
  input  logic [3:0]              s_axi_awqos,
  input  logic [USER_WIDTH-1:0]   s_axi_awuser,
  // W slave
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  // B slave
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic [USER_WIDTH-1:0]   s_axi_buser,
  // AR slave
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic [2:0]              s_axi_arprot,
  input  logic [3:0]              s_axi_arcache,
  input  logic                    s_axi_arlock,
  input  logic [3:0]              s_axi_arqos,
  input  logic [USER_WIDTH-1:0]   s_axi_aruser,
  // R slave
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic [USER_WIDTH-1:0]   s_axi_ruser,
  // AW master
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [ID_WIDTH-1:0]     m_axi_awid,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic [2:0]              m_axi_awprot,
  output logic [3:0]              m_axi_awcache,
  output logic                    m_axi_awlock,
  output logic [3:0]              m_axi_awqos,
  output logic [USER_WIDTH-1:0]   m_axi_awuser,
  // W master
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  // B master
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  input  logic [ID_WIDTH-1:0]     m_axi_bid,
  input  logic [1:0]              m_axi_bresp,
  input  logic [USER_WIDTH-1:0]   m_axi_buser,
  // AR master
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [ID_WIDTH-1:0]     m_axi_arid,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic [2:0]              m_axi_arprot,
  output logic [3:0]              m_axi_arcache,
  output logic                    m_axi_arlock,
  output logic [3:0]              m_axi_arqos,
  output logic [USER_WIDTH-1:0]   m_axi_aruser,
  // R master
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  input  logic [ID_WIDTH-1:0]     m_axi_rid,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic [USER_WIDTH-1:0]   m_axi_ruser
);

  localparam int A_PL = ADDR_WIDTH + ID_WIDTH + 25 + USER_WIDTH;
  localparam int W_PL = DATA_WIDTH + DATA_WIDTH/8 + 1;
  localparam int B_PL = ID_WIDTH + 2 + USER_WIDTH;
  localparam int R_PL = ID_WIDTH + DATA_WIDTH + 3 + USER_WIDTH;

  logic [A_PL-1:0] aw_in, aw_out, ar_in, ar_out;
  logic [W_PL-1:0] w_in, w_out;
  logic [B_PL-1:0] b_in, b_out;
  logic [R_PL-1:0] r_in, r_out;

  assign aw_in = {s_axi_awaddr, s_axi_awid, s_axi_awlen, s_axi_awsize, s_axi_awburst,
                  s_axi_awprot, s_axi_awcache, s_axi_awlock, s_axi_awqos, s_axi_awuser};
  assign {m_axi_awaddr, m_axi_awid, m_axi_awlen, m_axi_awsize, m_axi_awburst,
          m_axi_awprot, m_axi_awcache, m_axi_awlock, m_axi_awqos, m_axi_awuser} = aw_out;

  assign ar_in = {s_axi_araddr, s_axi_arid, s_axi_arlen, s_axi_arsize, s_axi_arburst,
                  s_axi_arprot, s_axi_arcache, s_axi_arlock, s_axi_arqos, s_axi_aruser};
  assign {m_axi_araddr, m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arburst,
          m_axi_arprot, m_axi_arcache, m_axi_arlock, m_axi_arqos, m_axi_aruser} = ar_out;

  assign w_in = {s_axi_wdata, s_axi_wstrb, s_axi_wlast};
  assign {m_axi_wdata, m_axi_wstrb, m_axi_wlast} = w_out;

  assign b_in = {m_axi_bid, m_axi_bresp, m_axi_buser};
  assign {s_axi_bid, s_axi_bresp, s_axi_buser} = b_out;

  assign r_in = {m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_ruser};
  assign {s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_ruser} = r_out;

  axi_reg_slice_chan #(.WIDTH(A_PL)) u_aw (
    .clk(uncoreclk), .rst(uncorerst),
    .in_valid(s_axi_awvalid), .in_ready(s_axi_awready), .in_data(aw_in),
    .out_valid(m_axi_awvalid), .out_ready(m_axi_awready), .out_data(aw_out));

  axi_reg_slice_chan #(.WIDTH(W_PL)) u_w (
    .clk(uncoreclk), .rst(uncorerst),
    .in_valid(s_axi_wvalid), .in_ready(s_axi_wready), .in_data(w_in),
    .out_valid(m_axi_wvalid), .out_ready(m_axi_wready), .out_data(w_out));

  axi_reg_slice_chan #(.WIDTH(B_PL)) u_b (
    .clk(uncoreclk), .rst(uncorerst),
    .in_valid(m_axi_bvalid), .in_ready(m_axi_bready), .in_data(b_in),
    .out_valid(s_axi_bvalid), .out_ready(s_axi_bready), .out_data(b_out));

  axi_reg_slice_chan #(.WIDTH(A_PL)) u_ar (
    .clk(uncoreclk), .rst(uncorerst),
    .in_valid(s_axi_arvalid), .in_ready(s_axi_arready), .in_data(ar_in),
    .out_valid(m_axi_arvalid), .out_ready(m_axi_arready), .out_data(ar_out));

  axi_reg_slice_chan #(.WIDTH(R_PL)) u_r (
    .clk(uncoreclk), .rst(uncorerst),
    .in_valid(m_axi_rvalid), .in_ready(m_axi_rready), .in_data(r_in),
    .out_valid(s_axi_rvalid), .out_ready(s_axi_rready), .out_data(r_out));

endmodule

`default_nettype wire

// File: tb/tb_axi_reg_slice.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_reg_slice
//  Purpose  : Self-checking bench for axi_reg_slice. Each channel is modelled
//             as an ordered queue holding at most two beats; a beat taken in
//             at one edge is visible at the output after that edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi_reg_slice;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int IW = 8;
  localparam int UW = 1;
  localparam int AP = AW + IW + 8 + 3 + 2 + 3 + 4 + 1 + 4 + UW;
  localparam int WP = DW + DW/8 + 1;
  localparam int BP = IW + 2 + UW;
  localparam int RP = IW + DW + 2 + 1 + UW;

  logic uncoreclk = 1'b0;
  logic uncorerst = 1'b0;
  always #5 uncoreclk = ~uncoreclk;

  // AW
  logic s_axi_awvalid = 1'b0, s_axi_awready;
  logic [AW-1:0] s_axi_awaddr; logic [IW-1:0] s_axi_awid; logic [7:0] s_axi_awlen;
  logic [2:0] s_axi_awsize; logic [1:0] s_axi_awburst; logic [2:0] s_axi_awprot;
  logic [3:0] s_axi_awcache; logic s_axi_awlock; logic [3:0] s_axi_awqos; logic [UW-1:0] s_axi_awuser;
  logic m_axi_awvalid, m_axi_awready = 1'b0;
  logic [AW-1:0] m_axi_awaddr; logic [IW-1:0] m_axi_awid; logic [7:0] m_axi_awlen;
  logic [2:0] m_axi_awsize; logic [1:0] m_axi_awburst; logic [2:0] m_axi_awprot;
  logic [3:0] m_axi_awcache; logic m_axi_awlock; logic [3:0] m_axi_awqos; logic [UW-1:0] m_axi_awuser;
  // AR
  logic s_axi_arvalid = 1'b0, s_axi_arready;
  logic [AW-1:0] s_axi_araddr; logic [IW-1:0] s_axi_arid; logic [7:0] s_axi_arlen;
  logic [2:0] s_axi_arsize; logic [1:0] s_axi_arburst; logic [2:0] s_axi_arprot;
  logic [3:0] s_axi_arcache; logic s_axi_arlock; logic [3:0] s_axi_arqos; logic [UW-1:0] s_axi_aruser;
  logic m_axi_arvalid, m_axi_arready = 1'b0;
  logic [AW-1:0] m_axi_araddr; logic [IW-1:0] m_axi_arid; logic [7:0] m_axi_arlen;
  logic [2:0] m_axi_arsize; logic [1:0] m_axi_arburst; logic [2:0] m_axi_arprot;
  logic [3:0] m_axi_arcache; logic m_axi_arlock; logic [3:0] m_axi_arqos; logic [UW-1:0] m_axi_aruser;
  // W
  logic s_axi_wvalid = 1'b0, s_axi_wready;
  logic [DW-1:0] s_axi_wdata; logic [DW/8-1:0] s_axi_wstrb; logic s_axi_wlast;
  logic m_axi_wvalid, m_axi_wready = 1'b0;
  logic [DW-1:0] m_axi_wdata; logic [DW/8-1:0] m_axi_wstrb; logic m_axi_wlast;
  // B
  logic s_axi_bvalid, s_axi_bready = 1'b0;
  logic [IW-1:0] s_axi_bid; logic [1:0] s_axi_bresp; logic [UW-1:0] s_axi_buser;
  logic m_axi_bvalid = 1'b0, m_axi_bready;
  logic [IW-1:0] m_axi_bid; logic [1:0] m_axi_bresp; logic [UW-1:0] m_axi_buser;
  // R
  logic s_axi_rvalid, s_axi_rready = 1'b0;
  logic [IW-1:0] s_axi_rid; logic [DW-1:0] s_axi_rdata; logic [1:0] s_axi_rresp;
  logic s_axi_rlast; logic [UW-1:0] s_axi_ruser;
  logic m_axi_rvalid = 1'b0, m_axi_rready;
  logic [IW-1:0] m_axi_rid; logic [DW-1:0] m_axi_rdata; logic [1:0] m_axi_rresp;
  logic m_axi_rlast; logic [UW-1:0] m_axi_ruser;

  // Packed payload views
  logic [AP-1:0] s_aw_pl = '0, m_aw_pl, s_ar_pl = '0, m_ar_pl;
  logic [WP-1:0] s_w_pl = '0, m_w_pl;
  logic [BP-1:0] m_b_pl = '0, s_b_pl;
  logic [RP-1:0] m_r_pl = '0, s_r_pl;
  logic [4:0]    valids, readies;

  assign {s_axi_awaddr, s_axi_awid, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awprot,
          s_axi_awcache, s_axi_awlock, s_axi_awqos, s_axi_awuser} = s_aw_pl;
  assign m_aw_pl = {m_axi_awaddr, m_axi_awid, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awprot,
                    m_axi_awcache, m_axi_awlock, m_axi_awqos, m_axi_awuser};
  assign {s_axi_araddr, s_axi_arid, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arprot,
          s_axi_arcache, s_axi_arlock, s_axi_arqos, s_axi_aruser} = s_ar_pl;
  assign m_ar_pl = {m_axi_araddr, m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arprot,
                    m_axi_arcache, m_axi_arlock, m_axi_arqos, m_axi_aruser};
  assign {s_axi_wdata, s_axi_wstrb, s_axi_wlast} = s_w_pl;
  assign m_w_pl = {m_axi_wdata, m_axi_wstrb, m_axi_wlast};
  assign {m_axi_bid, m_axi_bresp, m_axi_buser} = m_b_pl;
  assign s_b_pl = {s_axi_bid, s_axi_bresp, s_axi_buser};
  assign {m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_ruser} = m_r_pl;
  assign s_r_pl = {s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_ruser};
  assign valids  = {m_axi_awvalid, m_axi_wvalid, s_axi_bvalid, m_axi_arvalid, s_axi_rvalid};
  assign readies = {s_axi_awready, s_axi_wready, m_axi_bready, s_axi_arready, m_axi_rready};

  axi_reg_slice #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .USER_WIDTH(UW)) dut (
    .uncoreclk(uncoreclk), .uncorerst(uncorerst),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awaddr(s_axi_awaddr),
    .s_axi_awid(s_axi_awid), .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize),
    .s_axi_awburst(s_axi_awburst), .s_axi_awprot(s_axi_awprot), .s_axi_awcache(s_axi_awcache),
    .s_axi_awlock(s_axi_awlock), .s_axi_awqos(s_axi_awqos), .s_axi_awuser(s_axi_awuser),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
    .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bid(s_axi_bid),
    .s_axi_bresp(s_axi_bresp), .s_axi_buser(s_axi_buser),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_araddr(s_axi_araddr),
    .s_axi_arid(s_axi_arid), .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize),
    .s_axi_arburst(s_axi_arburst), .s_axi_arprot(s_axi_arprot), .s_axi_arcache(s_axi_arcache),
    .s_axi_arlock(s_axi_arlock), .s_axi_arqos(s_axi_arqos), .s_axi_aruser(s_axi_aruser),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rid(s_axi_rid),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
    .s_axi_ruser(s_axi_ruser),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_awaddr(m_axi_awaddr),
    .m_axi_awid(m_axi_awid), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awprot(m_axi_awprot), .m_axi_awcache(m_axi_awcache),
    .m_axi_awlock(m_axi_awlock), .m_axi_awqos(m_axi_awqos), .m_axi_awuser(m_axi_awuser),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_wdata(m_axi_wdata),
    .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bid(m_axi_bid),
    .m_axi_bresp(m_axi_bresp), .m_axi_buser(m_axi_buser),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr),
    .m_axi_arid(m_axi_arid), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arprot(m_axi_arprot), .m_axi_arcache(m_axi_arcache),
    .m_axi_arlock(m_axi_arlock), .m_axi_arqos(m_axi_arqos), .m_axi_aruser(m_axi_aruser),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rid(m_axi_rid),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_ruser(m_axi_ruser)
  );

  int checks = 0;
  int passes = 0;

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge uncoreclk);
    #1;
  endtask

  task automatic test_reset();
    uncorerst = 1'b0;
    #1 uncorerst = 1'b1;
    #1;
    checks++; if (valids !== 5'b0) $display("FAIL reset_valids: got %b want 00000", valids); else passes++;
    checks++; if (readies !== 5'b0) $display("FAIL reset_readies: got %b want 00000", readies); else passes++;
    tick(); tick();
    checks++; if (readies !== 5'b0) $display("FAIL reset_readies_held: got %b want 00000", readies); else passes++;
    uncorerst = 1'b0;
    tick();
    checks++; if (readies !== 5'b11111) $display("FAIL reset_release_readies: got %b want 11111", readies); else passes++;
    checks++; if (valids !== 5'b0) $display("FAIL reset_release_valids: got %b want 00000", valids); else passes++;
  endtask

  // AW addresses 0x1000..0x100F with the consumer always ready.
  task automatic test_stream();
    logic [127:0] r;
    logic [AP-1:0] exp_pl;
    m_axi_awready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      r = rnd128();
      exp_pl = {32'h1000 + 32'(i), r[AP-AW-1:0]};
      s_aw_pl = exp_pl;
      s_axi_awvalid = 1'b1;
      checks++; if (s_axi_awready !== 1'b1) $display("FAIL stream_awready beat %0d: got %b want 1", i, s_axi_awready); else passes++;
      tick();
      checks++;
      if (m_axi_awvalid !== 1'b1 || m_aw_pl !== exp_pl)
        $display("FAIL stream_out beat %0d: valid %b payload %h want valid 1 payload %h", i, m_axi_awvalid, m_aw_pl, exp_pl);
      else passes++;
    end
    s_axi_awvalid = 1'b0;
    tick();
    checks++; if (m_axi_awvalid !== 1'b0) $display("FAIL stream_drain: got valid %b want 0", m_axi_awvalid); else passes++;
  endtask

  // W data 0xA, 0xB, 0xC with the consumer stalled, then released.
  task automatic test_backpressure();
    logic [WP-1:0] w [3];
    logic [127:0] r;
    int outs;
    logic in_hs, out_hs;
    for (int k = 0; k < 3; k++) begin
      r = rnd128();
      w[k] = {64'(10 + k), r[8:0]};
    end
    m_axi_wready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      s_axi_wvalid = 1'b1;
      s_w_pl = w[k];
      checks++; if (s_axi_wready !== 1'b1) $display("FAIL bp_accept beat %0d: got ready %b want 1", k, s_axi_wready); else passes++;
      tick();
      checks++;
      if (m_axi_wvalid !== 1'b1 || m_w_pl !== w[0])
        $display("FAIL bp_head beat %0d: valid %b payload %h want 1 %h", k, m_axi_wvalid, m_w_pl, w[0]);
      else passes++;
    end
    s_w_pl = w[2];
    for (int k = 0; k < 3; k++) begin
      checks++; if (s_axi_wready !== 1'b0) $display("FAIL bp_full cycle %0d: got ready %b want 0", k, s_axi_wready); else passes++;
      checks++;
      if (m_axi_wvalid !== 1'b1 || m_w_pl !== w[0])
        $display("FAIL bp_stable cycle %0d: valid %b payload %h want 1 %h", k, m_axi_wvalid, m_w_pl, w[0]);
      else passes++;
      tick();
    end
    m_axi_wready = 1'b1;
    outs = 0;
    for (int c = 0; c < 10; c++) begin
      in_hs  = s_axi_wvalid && s_axi_wready;
      out_hs = m_axi_wvalid && m_axi_wready;
      if (out_hs) begin
        checks++;
        if (outs > 2 || m_w_pl !== w[outs > 2 ? 2 : outs])
          $display("FAIL bp_order out %0d: payload %h want %h", outs, m_w_pl, w[outs > 2 ? 2 : outs]);
        else passes++;
        outs++;
      end
      tick();
      if (in_hs) s_axi_wvalid = 1'b0;
    end
    checks++; if (outs !== 3) $display("FAIL bp_count: got %0d beats want 3", outs); else passes++;
    checks++; if (m_axi_wvalid !== 1'b0) $display("FAIL bp_empty: got valid %b want 0", m_axi_wvalid); else passes++;
    m_axi_wready = 1'b0;
  endtask

  // R channel: 1000 beats, random producer valid and consumer ready.
  task automatic test_random_r();
    logic [RP-1:0] sent_list [$];
    logic [RP-1:0] fifo_model [$];
    logic [127:0] r;
    logic [RP-1:0] prev_pl;
    logic prev_stall, in_hs, out_hs;
    int sent, recv, cyc;
    sent = 0; recv = 0; cyc = 0; prev_stall = 1'b0; prev_pl = '0;
    m_axi_rvalid = 1'b0;
    while (recv < 1000 && cyc < 20000) begin
      if (!m_axi_rvalid && sent < 1000 && $urandom_range(0, 3) != 0) begin
        r = rnd128();
        m_r_pl = {8'h5A, r[63:0], r[65:64], (sent % 8 == 7), r[66 +: UW]};
        sent_list.push_back(m_r_pl);
        sent++;
        m_axi_rvalid = 1'b1;
      end
      s_axi_rready = 1'($urandom_range(0, 1));
      checks++;
      if (s_axi_rvalid !== (fifo_model.size() > 0) || m_axi_rready !== (fifo_model.size() < 2))
        $display("FAIL rnd_flags cyc %0d: valid %b ready %b occupancy %0d", cyc, s_axi_rvalid, m_axi_rready, fifo_model.size());
      else passes++;
      if (fifo_model.size() > 0) begin
        checks++;
        if (s_r_pl !== fifo_model[0]) $display("FAIL rnd_head cyc %0d: payload %h want %h", cyc, s_r_pl, fifo_model[0]);
        else passes++;
      end
      if (prev_stall) begin
        checks++;
        if (s_axi_rvalid !== 1'b1 || s_r_pl !== prev_pl)
          $display("FAIL rnd_stable cyc %0d: valid %b payload %h want 1 %h", cyc, s_axi_rvalid, s_r_pl, prev_pl);
        else passes++;
      end
      in_hs  = m_axi_rvalid && m_axi_rready;
      out_hs = s_axi_rvalid && s_axi_rready;
      if (out_hs) begin
        checks++;
        if (recv >= sent_list.size() || s_r_pl !== sent_list[recv])
          $display("FAIL rnd_scoreboard beat %0d: payload %h", recv, s_r_pl);
        else passes++;
        recv++;
      end
      prev_stall = s_axi_rvalid && !s_axi_rready;
      prev_pl = s_r_pl;
      tick();
      cyc++;
      if (out_hs && fifo_model.size() > 0) void'(fifo_model.pop_front());
      if (in_hs) begin
        fifo_model.push_back(m_r_pl);
        m_axi_rvalid = 1'b0;
      end
    end
    checks++; if (recv !== 1000) $display("FAIL rnd_count: got %0d beats want 1000", recv); else passes++;
    m_axi_rvalid = 1'b0;
    s_axi_rready = 1'b0;
  endtask

  // Two beats parked in B, then reset pulsed between clock edges.
  task automatic test_reset_mid();
    logic [BP-1:0] b0, b1;
    logic [127:0] r;
    r = rnd128();
    b0 = r[BP-1:0];
    b1 = r[2*BP-1:BP];
    s_axi_bready = 1'b0;
    m_axi_bvalid = 1'b1; m_b_pl = b0; tick();
    m_b_pl = b1; tick();
    m_axi_bvalid = 1'b0;
    checks++;
    if (s_axi_bvalid !== 1'b1 || s_b_pl !== b0 || m_axi_bready !== 1'b0)
      $display("FAIL rstmid_loaded: valid %b payload %h ready %b want 1 %h 0", s_axi_bvalid, s_b_pl, m_axi_bready, b0);
    else passes++;
    #2 uncorerst = 1'b1;
    #1;
    checks++; if (valids !== 5'b0) $display("FAIL rstmid_valids_async: got %b want 00000", valids); else passes++;
    checks++; if (readies !== 5'b0) $display("FAIL rstmid_readies_async: got %b want 00000", readies); else passes++;
    tick(); tick();
    checks++; if (readies !== 5'b0) $display("FAIL rstmid_readies_held: got %b want 00000", readies); else passes++;
    uncorerst = 1'b0;
    #1;
    checks++; if (readies !== 5'b0) $display("FAIL rstmid_readies_preedge: got %b want 00000", readies); else passes++;
    tick();
    checks++; if (readies !== 5'b11111) $display("FAIL rstmid_readies_release: got %b want 11111", readies); else passes++;
    s_axi_bready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (s_axi_bvalid !== 1'b0) $display("FAIL rstmid_stale cycle %0d: got valid %b want 0", k, s_axi_bvalid); else passes++;
      tick();
    end
    s_axi_bready = 1'b0;
  endtask

  // AR stalled while AW streams 8 beats.
  task automatic test_independence();
    logic [AP-1:0] aw [8];
    logic [AP-1:0] ar [3];
    int ar_acc;
    logic ar_hs;
    for (int k = 0; k < 8; k++) aw[k] = AP'(rnd128());
    for (int k = 0; k < 3; k++) ar[k] = AP'(rnd128());
    m_axi_arready = 1'b0;
    m_axi_awready = 1'b1;
    ar_acc = 0;
    for (int c = 0; c < 9; c++) begin
      s_axi_awvalid = (c < 8);
      if (c < 8) s_aw_pl = aw[c];
      s_axi_arvalid = 1'b1;
      s_ar_pl = ar[ar_acc];
      if (c < 8) begin
        checks++; if (s_axi_awready !== 1'b1) $display("FAIL indep_awready cyc %0d: got %b want 1", c, s_axi_awready); else passes++;
      end
      ar_hs = s_axi_arvalid && s_axi_arready;
      tick();
      if (ar_hs) ar_acc++;
      if (c < 8) begin
        checks++;
        if (m_axi_awvalid !== 1'b1 || m_aw_pl !== aw[c])
          $display("FAIL indep_aw_out cyc %0d: valid %b payload %h want 1 %h", c, m_axi_awvalid, m_aw_pl, aw[c]);
        else passes++;
      end
      checks++;
      if (m_axi_arvalid !== 1'b1 || m_ar_pl !== ar[0] || s_axi_arready !== (ar_acc < 2))
        $display("FAIL indep_ar cyc %0d: valid %b ready %b payload %h accepted %0d", c, m_axi_arvalid, s_axi_arready, m_ar_pl, ar_acc);
      else passes++;
    end
    checks++; if (ar_acc !== 2) $display("FAIL indep_ar_count: got %0d want 2", ar_acc); else passes++;
    s_axi_arvalid = 1'b0;
    s_axi_awvalid = 1'b0;
    m_axi_arready = 1'b1;
    tick();
    checks++;
    if (m_axi_arvalid !== 1'b1 || m_ar_pl !== ar[1] || m_axi_awvalid !== 1'b0)
      $display("FAIL indep_drain1: arvalid %b payload %h awvalid %b want 1 %h 0", m_axi_arvalid, m_ar_pl, m_axi_awvalid, ar[1]);
    else passes++;
    tick();
    checks++; if (m_axi_arvalid !== 1'b0) $display("FAIL indep_drain2: got arvalid %b want 0", m_axi_arvalid); else passes++;
  endtask

  // One beat resident, then push and pop on the same edge for 10 cycles.
  task automatic test_push_pop();
    logic [AP-1:0] p [11];
    for (int k = 0; k < 11; k++) p[k] = AP'(rnd128());
    m_axi_arready = 1'b0;
    checks++; if (s_axi_arready !== 1'b1) $display("FAIL pp_preload_ready: got %b want 1", s_axi_arready); else passes++;
    s_axi_arvalid = 1'b1;
    s_ar_pl = p[0];
    tick();
    m_axi_arready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      s_ar_pl = p[i];
      checks++;
      if (s_axi_arready !== 1'b1 || m_axi_arvalid !== 1'b1 || m_ar_pl !== p[i-1])
        $display("FAIL pp_cycle %0d: ready %b valid %b payload %h want 1 1 %h", i, s_axi_arready, m_axi_arvalid, m_ar_pl, p[i-1]);
      else passes++;
      tick();
    end
    s_axi_arvalid = 1'b0;
    checks++;
    if (m_axi_arvalid !== 1'b1 || m_ar_pl !== p[10])
      $display("FAIL pp_last: valid %b payload %h want 1 %h", m_axi_arvalid, m_ar_pl, p[10]);
    else passes++;
    tick();
    checks++;
    if (m_axi_arvalid !== 1'b0 || s_axi_arready !== 1'b1)
      $display("FAIL pp_empty: valid %b ready %b want 0 1", m_axi_arvalid, s_axi_arready);
    else passes++;
    m_axi_arready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_random_r();
    test_reset_mid();
    test_independence();
    test_push_pop();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passes, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
